// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
//   Shared types and defaults for the register-file write arbiter.
//   - arb_state_t : top-level sequencing state (zero-fill vs. normal run)
//   - req_id_t    : requester identity; the numeric value doubles as the
//                   bit index of that requester in the req/grant vectors
//   - default widths for address, data and stall counters
//   - other_req() : the requester that is not the given one (round-robin)
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int RF_ARB_PW  = 4;  // register address width
  localparam int RF_ARB_DW  = 8;  // register data width
  localparam int RF_ARB_SCW = 8;  // stall counter width

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;

  // The requester that should win a tie when 'r' was granted last.
  function automatic req_id_t other_req(input req_id_t r);
    req_id_t o;
    case (r)
      REQ_ALU: o = REQ_LD;
      REQ_LD:  o = REQ_ALU;
      default: o = REQ_ALU;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. A single request is always granted;
//   on a tie the requester that was not granted last wins. The "last
//   granted" pointer moves only when a grant is actually issued, so idle
//   cycles and disabled cycles leave the fairness order untouched.
// Ports
//   clk     in  1  clock
//   reset   in  1  synchronous active-high reset (pointer -> REQ_LD, so
//                  REQ_ALU wins the first tie)
//   en      in  1  arbitration enable; no grant while low
//   req     in  2  request vector, bit 0 = ALU, bit 1 = LOAD
//   grant   out 2  one-hot (or zero) grant, combinational
// ---------------------------------------------------------------------------
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_t last;

  // Grant decision: pass single requests through, break ties by pointer.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        if (other_req(last) == REQ_ALU) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end else begin
        grant = req;
      end
    end else begin
      grant = 2'b00;
    end
  end

  // Remember who was granted last; only a real grant moves the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= REQ_LD;
    end else if (grant[0]) begin
      last <= REQ_ALU;
    end else if (grant[1]) begin
      last <= REQ_LD;
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Owns the single write port of the register file and shares it between
//   the ALU and LOAD writeback paths with a valid/ready handshake and
//   round-robin tie-breaking. After reset or clr_req every register is
//   zero-filled (one address per cycle, 2**PW cycles) before any request
//   is accepted. Accepted writes appear on the registered rf_* outputs one
//   cycle after the handshake.
//
// Configuration macro
//   RF_ARB_BYPASS_EN : adds two read-port forwarding muxes so a reader sees
//                      the value currently being written (rd_addrA/B,
//                      rf_datA/B in; fwd_datA/B out). Absent by default.
//
// Ports
//   clk            in   1    clock, all state on posedge
//   reset          in   1    synchronous active-high reset
//   clr_req        in   1    pulse: restart the zero-fill sequence
//   alu_valid/addr/data in   ALU write request
//   alu_ready      out  1    ALU request accepted this cycle (combinational)
//   ld_valid/addr/data  in   LOAD write request
//   ld_ready       out  1    LOAD request accepted this cycle (combinational)
//   rf_wr_en       out  1    register file write enable (registered)
//   rf_wr_addr     out  PW   register file write address (registered)
//   rf_dat_in      out  DW   register file write data (registered)
//   busy           out  1    high while zero-fill is in progress
//   alu_stall_cnt  out  SCW  saturating count of ALU stall cycles
//   ld_stall_cnt   out  SCW  saturating count of LOAD stall cycles
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int PW  = RF_ARB_PW,
  parameter int DW  = RF_ARB_DW,
  parameter int SCW = RF_ARB_SCW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr_req,
  input  logic           alu_valid,
  input  logic [PW-1:0]  alu_addr,
  input  logic [DW-1:0]  alu_data,
  output logic           alu_ready,
  input  logic           ld_valid,
  input  logic [PW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic           ld_ready,
`ifdef RF_ARB_BYPASS_EN
  input  logic [PW-1:0]  rd_addrA,
  input  logic [PW-1:0]  rd_addrB,
  input  logic [DW-1:0]  rf_datA,
  input  logic [DW-1:0]  rf_datB,
  output logic [DW-1:0]  fwd_datA,
  output logic [DW-1:0]  fwd_datB,
`endif
  output logic           rf_wr_en,
  output logic [PW-1:0]  rf_wr_addr,
  output logic [DW-1:0]  rf_dat_in,
  output logic           busy,
  output logic [SCW-1:0] alu_stall_cnt,
  output logic [SCW-1:0] ld_stall_cnt
);

  localparam logic [PW-1:0]  FILL_LAST = {PW{1'b1}};
  localparam logic [SCW-1:0] STALL_MAX = {SCW{1'b1}};

  arb_state_t    state;
  logic [PW-1:0] fill_cnt;
  logic          arb_en;
  logic [1:0]    grant;

  // Arbitration only in RUN; clr_req and reset suppress any grant that cycle.
  assign arb_en = (state == S_RUN) && !clr_req && !reset;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({ld_valid, alu_valid}),
    .grant (grant)
  );

  // Bit positions follow req_id_t: bit 0 = ALU, bit 1 = LOAD.
  assign alu_ready = grant[0];
  assign ld_ready  = grant[1];

  // Sequencer: zero-fill in S_CLEAR, forward the granted request in S_RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      fill_cnt   <= {PW{1'b0}};
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= {PW{1'b0}};
      rf_dat_in  <= {DW{1'b0}};
      busy       <= 1'b1;
    end else if (clr_req) begin
      // Restart the fill from address 0; no write is issued this cycle.
      state    <= S_CLEAR;
      fill_cnt <= {PW{1'b0}};
      rf_wr_en <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= fill_cnt;
          rf_dat_in  <= {DW{1'b0}};
          fill_cnt   <= fill_cnt + 1'b1;
          // busy drops together with the edge that issues the last address.
          if (fill_cnt == FILL_LAST) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end else begin
            state <= S_CLEAR;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          busy <= 1'b0;
          if (grant[0]) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= alu_addr;
            rf_dat_in  <= alu_data;
          end else if (grant[1]) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= ld_addr;
            rf_dat_in  <= ld_data;
          end else begin
            // Address/data hold their last value while idle.
            rf_wr_en <= 1'b0;
          end
        end
        default: begin
          state    <= S_CLEAR;
          fill_cnt <= {PW{1'b0}};
          rf_wr_en <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  // Stall counters: count valid-without-ready cycles, saturate, clear on clr_req.
  always_ff @(posedge clk) begin
    if (reset || clr_req) begin
      alu_stall_cnt <= {SCW{1'b0}};
      ld_stall_cnt  <= {SCW{1'b0}};
    end else begin
      if (alu_valid && !alu_ready && (alu_stall_cnt != STALL_MAX)) begin
        alu_stall_cnt <= alu_stall_cnt + 1'b1;
      end
      if (ld_valid && !ld_ready && (ld_stall_cnt != STALL_MAX)) begin
        ld_stall_cnt <= ld_stall_cnt + 1'b1;
      end
    end
  end

`ifdef RF_ARB_BYPASS_EN
  // Read-port forwarding: a read of the address being written sees new data.
  always_comb begin
    fwd_datA = rf_datA;
    fwd_datB = rf_datB;
    if (rf_wr_en && (rf_wr_addr == rd_addrA)) begin
      fwd_datA = rf_dat_in;
    end else begin
      fwd_datA = rf_datA;
    end
    if (rf_wr_en && (rf_wr_addr == rd_addrB)) begin
      fwd_datB = rf_dat_in;
    end else begin
      fwd_datB = rf_datB;
    end
  end
`endif

endmodule
